// File: rtl/wav_ahb_reg_bridge_if.sv
// AHB-Lite slave-side bus plus the request/acknowledge register port of wav_ahb_reg_bridge.
interface wav_ahb_reg_bridge_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              i_ahb_hsel;
  logic [AWIDTH-1:0] i_ahb_haddr;
  logic              i_ahb_hwrite;
  logic [1:0]        i_ahb_htrans;
  logic [2:0]        i_ahb_hsize;
  logic [2:0]        i_ahb_hburst;
  logic [DWIDTH-1:0] i_ahb_hwdata;
  logic              i_ahb_hready;
  logic              o_ahb_hreadyout;
  logic [1:0]        o_ahb_hresp;
  logic [DWIDTH-1:0] o_ahb_hrdata;

  logic                  o_reg_req;
  logic                  o_reg_write;
  logic [AWIDTH-1:0]     o_reg_addr;
  logic [DWIDTH-1:0]     o_reg_wdata;
  logic [DWIDTH/8-1:0]   o_reg_wstrb;
  logic                  i_reg_ack;
  logic [DWIDTH-1:0]     i_reg_rdata;
  logic                  i_reg_slverr;

  modport slave (
    input  i_ahb_hsel, i_ahb_haddr, i_ahb_hwrite, i_ahb_htrans, i_ahb_hsize,
    input  i_ahb_hburst, i_ahb_hwdata, i_ahb_hready,
    output o_ahb_hreadyout, o_ahb_hresp, o_ahb_hrdata,
    output o_reg_req, o_reg_write, o_reg_addr, o_reg_wdata, o_reg_wstrb,
    input  i_reg_ack, i_reg_rdata, i_reg_slverr
  );

  modport master (
    output i_ahb_hsel, i_ahb_haddr, i_ahb_hwrite, i_ahb_htrans, i_ahb_hsize,
    output i_ahb_hburst, i_ahb_hwdata, i_ahb_hready,
    input  o_ahb_hreadyout, o_ahb_hresp, o_ahb_hrdata,
    input  o_reg_req, o_reg_write, o_reg_addr, o_reg_wdata, o_reg_wstrb,
    output i_reg_ack, i_reg_rdata, i_reg_slverr
  );
endinterface

// File: rtl/wav_ahb_reg_bridge.sv
// AHB-Lite to one-outstanding register request bridge; request one cycle after the address phase,
// response one cycle after ack (min one wait state); HREADYOUT low stalls the bus while a request is open.
module wav_ahb_reg_bridge #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset,
  wav_ahb_reg_bridge_if.slave  bus,
  input  logic                 i_err_cnt_clr,
  output logic [7:0]           o_err_cnt
);
  localparam int SW = DWIDTH / 8;
  localparam int LB = $clog2(SW);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;

  typedef enum logic [1:0] {IDLE, REQ, ERR1, ERR2} state_t;

  state_t         state;
  logic [TW-1:0]  tcnt;
  logic           first;
  logic           xfer_vld;
  logic           xfer_ok;
  logic           tmo_hit;
  logic           err_entry;
  logic [SW-1:0]  strb;
  logic           unused;

  assign unused = ^bus.i_ahb_hburst;

  assign xfer_vld = bus.i_ahb_hsel & bus.i_ahb_hready & bus.i_ahb_htrans[1]
                  & ((state == IDLE) | (state == ERR2));
  assign tmo_hit  = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT));
  assign err_entry = (xfer_vld & ~xfer_ok)
                   | ((state == REQ) & bus.i_reg_ack & bus.i_reg_slverr)
                   | ((state == REQ) & ~bus.i_reg_ack & tmo_hit);

  // Legality and little-endian lane mask; reads always enable every lane.
  always_comb begin
    int off;
    int nb;
    off = int'(bus.i_ahb_haddr[LB-1:0]);
    nb  = 1 << bus.i_ahb_hsize;
    xfer_ok = (int'(bus.i_ahb_hsize) <= LB) && ((off & (nb - 1)) == 0);
    for (int i = 0; i < SW; i++) begin
      strb[i] = bus.i_ahb_hwrite ? ((i >= off) && (i < off + nb)) : 1'b1;
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state               <= IDLE;
      bus.o_ahb_hreadyout <= 1'b1;
      bus.o_ahb_hresp     <= OKAY;
      bus.o_ahb_hrdata    <= '0;
      bus.o_reg_req       <= 1'b0;
      bus.o_reg_write     <= 1'b0;
      bus.o_reg_addr      <= '0;
      bus.o_reg_wdata     <= '0;
      bus.o_reg_wstrb     <= '0;
      tcnt                <= '0;
      first               <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          state               <= IDLE;
          bus.o_ahb_hreadyout <= 1'b1;
          bus.o_ahb_hresp     <= OKAY;
          if (xfer_vld) begin
            bus.o_ahb_hreadyout <= 1'b0;
            if (xfer_ok) begin
              state           <= REQ;
              bus.o_reg_req   <= 1'b1;
              bus.o_reg_write <= bus.i_ahb_hwrite;
              bus.o_reg_addr  <= bus.i_ahb_haddr;
              bus.o_reg_wstrb <= strb;
              first           <= 1'b1;
              tcnt            <= TW'(1);
            end else begin
              state           <= ERR1;
              bus.o_ahb_hresp <= ERROR;
            end
          end
        end
        REQ: begin
          first <= 1'b0;
          if (first) bus.o_reg_wdata <= bus.i_ahb_hwdata;
          if (bus.i_reg_ack) begin
            bus.o_reg_req <= 1'b0;
            if (bus.i_reg_slverr) begin
              state           <= ERR1;
              bus.o_ahb_hresp <= ERROR;
            end else begin
              state               <= IDLE;
              bus.o_ahb_hreadyout <= 1'b1;
              if (!bus.o_reg_write) bus.o_ahb_hrdata <= bus.i_reg_rdata;
            end
          end else if (tmo_hit) begin
            bus.o_reg_req   <= 1'b0;
            state           <= ERR1;
            bus.o_ahb_hresp <= ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ERR1: begin
          state               <= ERR2;
          bus.o_ahb_hreadyout <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset || i_err_cnt_clr) begin
      o_err_cnt <= 8'd0;
    end else if (err_entry && (o_err_cnt != 8'hFF)) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
endmodule
